alu_mc_unit: RTL and testbench
==============================

ALU_MC_UNIT -- requirements
Module: alu_mc_unit

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first; one clock; reset is synchronous and active-high:
  clk  in  1  rising-edge clock, sole clock
  rst  in  1  synchronous, active-high reset
  req_valid  in  1  initiator presents an operation
  req_ready  out  1  unit can accept an operation
  alu_op  in  3  000 add, 001 xor, 010 sub, 011 mult, 100 slt, 101 nor, 110 and, 111 or
  a  in  32  operand A
  b  in  32  operand B
  rsp_valid  out  1  result available
  rsp_ready  in  1  initiator consumes the result
  res  out  32  result
  zero  out  1  res == 0
REQ-002 SHALL have no parameters; MULT_ITERS = 32 is fixed in the package.

Function
REQ-003 SHALL accept a request on a rising edge with req_valid && req_ready, capturing alu_op, a and b; the inputs are ignored at all other times.
REQ-004 SHALL have FSM states IDLE, MULT and DONE; req_ready = 1 only in IDLE.
REQ-005 IDLE, request accepted with op != 011: result registered, next state DONE; rsp_valid rises 1 cycle after acceptance.
REQ-006 IDLE, request accepted with op 011: next state MULT; shift-add, one multiplier bit per cycle, LSB first; MULT lasts MULT_ITERS cycles, then DONE; rsp_valid rises 33 cycles after acceptance.
REQ-007 DONE: rsp_valid = 1, and res/zero are held stable until rsp_valid && rsp_ready; next state IDLE.
REQ-008 There is no bypass from DONE to acceptance: the next acceptance is at the earliest 1 cycle after response consumption.
REQ-009 Arithmetic is modulo 2^32; mult returns the low 32 bits of the unsigned product; add/sub wrap silently; no overflow flag.
REQ-010 slt SHALL compare signed two's complement: res = 32'd1 if a < b, else 32'd0.
REQ-011 zero is registered with res in the same cycle; zero = (res == 32'd0).
REQ-012 rsp_ready asserted outside DONE SHALL have no effect; req_valid outside IDLE SHALL neither stall nor corrupt the operation in flight.

Reset
REQ-013 While rst = 1 at a clock edge:
  - state goes to IDLE;
  - rsp_valid = 0, res = 32'd0, zero = 0;
  - multiplier accumulator, multiplicand and multiplier registers are cleared.
REQ-014 req_ready SHALL be 0 during any cycle in which rst = 1, and 1 on the first cycle after rst deasserts.
REQ-015 Reset in MULT or DONE SHALL abort the operation; no response is ever issued for it.

Configuration
REQ-016 Macro ALU_MC_EARLY_TERM_EN:
  - Defined: MULT exits to DONE after the first iteration that leaves the remaining multiplier bits zero; minimum 1 MULT cycle; rsp_valid latency = 1 + max(1, index of highest set bit of b + 1) cycles.
  - Undefined: always MULT_ITERS iterations, fixed 33-cycle latency.
  - Results are identical either way.

Structure
REQ-017 Package alu_mc_pkg SHALL hold:
  - op-code constants OP_ADD..OP_OR;
  - FSM state typedef;
  - MULT_ITERS;
  - 32-bit word typedef.
REQ-018 Sub-module alu_mc_mul:
  - iterative shift-add multiplier with start/busy/done and a 32-bit product;
  - instantiated once;
  - single-cycle ops are implemented inline in alu_mc_unit.

Verification
REQ-019 add a=13, b=12 -> rsp_valid 1 cycle after acceptance, res=25, zero=0.
REQ-020 sub a=0x8000000D, b=0x8000000D -> res=0, zero=1; sub a=0x8000000D, b=0x8000000F -> res=0xFFFFFFFE.
REQ-021 mult a=13, b=12 -> res=156; latency 33 cycles without the macro, 5 cycles with ALU_MC_EARLY_TERM_EN.
REQ-022 slt a=0x0200000D, b=0x2200000C -> res=1; slt with a and b swapped -> res=0, zero=1; nor a=b=0x0200000D -> res=0xFDFFFFF2.
REQ-023 Backpressure: xor a=0x0200000D, b=0x0200000C, rsp_ready held 0 for 10 cycles -> res=1 held stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-024 Reset mid-mult: rst pulsed in MULT cycle 10 -> rsp_valid never rises; a following add 1+1 -> res=2.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU: op-codes, FSM states,
// multiplier iteration count and the datapath word type.
package alu_mc_pkg;

  localparam int MULT_ITERS = 32;
  localparam int MUL_CNT_W  = $clog2(MULT_ITERS);

  typedef logic [31:0] word_t;
  typedef logic [2:0]  op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_XOR  = 3'b001;
  localparam op_t OP_SUB  = 3'b010;
  localparam op_t OP_MULT = 3'b011;
  localparam op_t OP_SLT  = 3'b100;
  localparam op_t OP_NOR  = 3'b101;
  localparam op_t OP_AND  = 3'b110;
  localparam op_t OP_OR   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// ALU_MC_EARLY_TERM_EN: stop as soon as the remaining multiplier bits are zero.
module alu_mc_mul
  import alu_mc_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_start,
  input  word_t i_a,
  input  word_t i_b,
  output logic  o_busy,
  output logic  o_done,
  output word_t o_product
);

  word_t                r_acc;
  word_t                r_mcand;
  word_t                r_mplier;
  logic [MUL_CNT_W-1:0] r_cnt;
  logic                 r_busy;

  word_t w_acc_next;
  word_t w_mplier_next;
  logic  w_last;

  assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_next = r_mplier >> 1;

`ifdef ALU_MC_EARLY_TERM_EN
  // the counter still bounds the run; the zero test only ever ends it sooner
  assign w_last = (r_cnt == '0) || (w_mplier_next == '0);
`else
  assign w_last = (r_cnt == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= MUL_CNT_W'(MULT_ITERS - 1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_next;
      r_cnt    <= r_cnt - MUL_CNT_W'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

  // product is presented combinationally during the final iteration
  assign o_busy    = r_busy;
  assign o_done    = r_busy && w_last;
  assign o_product = w_acc_next;

endmodule

// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU with valid/ready request and response handshakes.
// Single-cycle ops are computed inline; mult uses alu_mc_mul.
//   state  | meaning
//   S_IDLE | ready for a request
//   S_MULT | shift-add multiply in progress
//   S_DONE | result valid, waiting for rsp_ready
module alu_mc_unit
  import alu_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] res,
  output logic        zero
);

  state_t r_state;
  state_t w_state_next;
  word_t  r_res;
  logic   r_zero;

  logic  w_accept;
  logic  w_is_mult;
  logic  w_mul_start;
  logic  w_mul_busy;
  logic  w_mul_done;
  word_t w_product;
  word_t w_alu_res;

  assign req_ready   = (r_state == S_IDLE) && !rst && !w_mul_busy;
  assign w_accept    = req_valid && req_ready;
  assign w_is_mult   = (alu_op == OP_MULT);
  assign w_mul_start = w_accept && w_is_mult;

  alu_mc_mul u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_comb begin
    w_alu_res = '0;
    case (alu_op)
      OP_ADD:  w_alu_res = a + b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_SUB:  w_alu_res = a - b;
      OP_SLT:  w_alu_res = {31'd0, ($signed(a) < $signed(b))};
      OP_NOR:  w_alu_res = ~(a | b);
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_next = w_is_mult ? S_MULT : S_DONE;
      S_MULT:  if (w_mul_done) w_state_next = S_DONE;
      S_DONE:  if (rsp_ready)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res  <= '0;
      r_zero <= 1'b0;
    end else if (r_state == S_IDLE && w_accept && !w_is_mult) begin
      r_res  <= w_alu_res;
      r_zero <= (w_alu_res == '0);
    end else if (r_state == S_MULT && w_mul_done) begin
      r_res  <= w_product;
      r_zero <= (w_product == '0);
    end
  end

  assign rsp_valid = (r_state == S_DONE);
  assign res       = r_res;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_mc_unit.sv
// Self-checking bench for alu_mc_unit; expectations queued at request time,
// popped when the response appears.
`timescale 1ns/1ps
module tb_alu_mc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] res;
  logic        zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] q_res[$];
  int          q_lat[$];

  alu_mc_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .res       (res),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'b000:  return x + y;
      3'b001:  return x ^ y;
      3'b010:  return x - y;
      3'b011:  return x * y;
      3'b100:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b101:  return ~(x | y);
      3'b110:  return x & y;
      default: return x | y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] y);
    if (op != 3'b011) return 1;
`ifdef ALU_MC_EARLY_TERM_EN
    begin
      int nbits = 0;
      for (int i = 0; i < 32; i++) if (y[i]) nbits = i + 1;
      return 1 + ((nbits < 1) ? 1 : nbits);
    end
`else
    return 33;
`endif
  endfunction

  task automatic wait_ready(input string name);
    int wt = 0;
    while (req_ready !== 1'b1 && wt < 50) begin
      @(posedge clk); #1; wt++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready got=%b want=1", name, req_ready);
    end
  endtask

  // one complete transaction; stall = cycles rsp_ready is withheld in DONE
  task automatic do_txn(input string name, input logic [2:0] op, input logic [31:0] xa,
                        input logic [31:0] xb, input logic [31:0] exp_res, input int exp_lat,
                        input int stall);
    int lat;
    logic [31:0] e_res;
    int e_lat;
    wait_ready(name);
    alu_op = op; a = xa; b = xb; req_valid = 1'b1;
    q_res.push_back(exp_res);
    q_lat.push_back(exp_lat);
    @(posedge clk); #1;
    req_valid = 1'b0; alu_op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    e_res = q_res.pop_front();
    e_lat = q_lat.pop_front();
    total++;
    if (lat != e_lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, e_lat); end
    total++;
    if (res !== e_res) begin bad++; $display("FAIL %s_res got=%h want=%h", name, res, e_res); end
    total++;
    if (zero !== (e_res == 32'd0)) begin bad++; $display("FAIL %s_zero got=%b want=%b", name, zero, (e_res == 32'd0)); end
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL %s_ready_in_done got=%b want=0", name, req_ready); end
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; alu_op = 3'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || res !== e_res) begin
        bad++;
        $display("FAIL %s_hold%0d got v=%b r=%b res=%h want v=1 r=0 res=%h", name, i, rsp_valid, req_ready, res, e_res);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL %s_consume got v=%b r=%b want v=0 r=1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || res !== 32'd0 || zero !== 1'b0) begin
        bad++;
        $display("FAIL reset%0d got r=%b v=%b res=%h z=%b want r=0 v=0 res=0 z=0", i, req_ready, rsp_valid, res, zero);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_spec_vectors;
    int mult_lat;
`ifdef ALU_MC_EARLY_TERM_EN
    mult_lat = 5;
`else
    mult_lat = 33;
`endif
    do_txn("add13_12", 3'b000, 32'd13, 32'd12, 32'd25, 1, 0);
    do_txn("sub_eq", 3'b010, 32'h8000000D, 32'h8000000D, 32'd0, 1, 0);
    do_txn("sub_neg", 3'b010, 32'h8000000D, 32'h8000000F, 32'hFFFFFFFE, 1, 0);
    do_txn("mult13_12", 3'b011, 32'd13, 32'd12, 32'd156, mult_lat, 0);
    do_txn("slt_lt", 3'b100, 32'h0200000D, 32'h2200000C, 32'd1, 1, 0);
    do_txn("slt_ge", 3'b100, 32'h2200000C, 32'h0200000D, 32'd0, 1, 0);
    do_txn("slt_signed", 3'b100, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0);
    do_txn("nor", 3'b101, 32'h0200000D, 32'h0200000D, 32'hFDFFFFF2, 1, 0);
    do_txn("add_wrap", 3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0);
    do_txn("mult_wrap", 3'b011, 32'h80000001, 32'h80000001, 32'h00000001, 33, 0);
    do_txn("mult_b0", 3'b011, 32'h12345678, 32'd0, 32'd0, model_lat(3'b011, 32'd0), 0);
  endtask

  task automatic test_backpressure;
    do_txn("bp_xor", 3'b001, 32'h0200000D, 32'h0200000C, 32'd1, 1, 10);
  endtask

  task automatic test_ignore_inputs;
    int lat;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL idle_rsp_ready%0d got v=%b r=%b want v=0 r=1", i, rsp_valid, req_ready);
      end
    end
    wait_ready("ign_mult");
    alu_op = 3'b011; a = 32'd7; b = 32'd9; req_valid = 1'b1;
    q_res.push_back(32'd63);
    q_lat.push_back(model_lat(3'b011, 32'd9));
    @(posedge clk); #1;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      alu_op = 3'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1; lat++;
    end
    req_valid = 1'b0;
    total++;
    if (lat != q_lat[0]) begin bad++; $display("FAIL ign_latency got=%0d want=%0d", lat, q_lat[0]); end
    void'(q_lat.pop_front());
    total++;
    if (res !== q_res[0]) begin bad++; $display("FAIL ign_res got=%h want=%h", res, q_res[0]); end
    void'(q_res.pop_front());
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL ign_consume got v=%b r=%b want v=0 r=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_mult;
    logic seen = 1'b0;
    wait_ready("rmm");
    alu_op = 3'b011; a = 32'd13; b = 32'h80000001; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL rmm_in_mult got v=%b r=%b want v=0 r=0", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (res !== 32'd0 || zero !== 1'b0) begin bad++; $display("FAIL rmm_cleared got res=%h z=%b want 0 0", res, zero); end
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rmm_no_rsp got seen=%b want 0", seen); end
    do_txn("rmm_add", 3'b000, 32'd1, 32'd1, 32'd2, 1, 0);
  endtask

  task automatic test_back_to_back;
    logic [2:0]  op;
    logic [31:0] xa, xb;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom);
      xa = $urandom;
      xb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      do_txn("rand", op, xa, xb, model_res(op, xa, xb), model_lat(op, xb), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    alu_op = 3'b000; a = 32'd0; b = 32'd0;
    test_reset();
    test_spec_vectors();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid_mult();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
